ascon_init_core: RTL and testbench

Round controller and state register that drives the Ascon permutation (`asconp_lut`) for the Ascon-128 initialization phase. It performs the following steps:
- loads IV‖K‖N into the five 64-bit lanes;
- iterates p^12 at UROL rounds per clock;
- applies the final key XOR;
- presents the initialized state downstream with a valid/ready handshake.

It also arbitrates runtime S-box LUT updates so they can only land while the permutation is idle.

---
 rtl/ascon_pkg.sv | 72 +++++++
 rtl/ascon_init_core_if.sv | 44 ++++
 rtl/ascon_init_core_asconp_lut.sv | 52 +++++
 rtl/ascon_init_core.sv | 107 ++++++++++
 tb/tb_ascon_init_core.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_pkg
//  Purpose  : Shared constants, types and the single-round datapath function
//             for the Ascon-128 initialization core.
//  Contents : ASCON128_IV, ROUNDS_A, ASCON_SBOX (reset LUT contents),
//             init_state_e (FSM), ascon_state_t (5x64 lanes), sbox_lut_t,
//             ror64(), ascon_round().
//  Revision : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    localparam logic [63:0] ASCON128_IV = 64'h80400C0600000000;
    localparam int unsigned ROUNDS_A    = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } init_state_e;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    // 32 entries of 5 bits; entry index = {x0,x1,x2,x3,x4} column bits.
    typedef logic [31:0][4:0] sbox_lut_t;

    // Standard Ascon S-box, listed from entry 31 down to entry 0.
    localparam sbox_lut_t ASCON_SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, LUT substitution, linear diffusion.
    function automatic ascon_state_t ascon_round(input ascon_state_t s,
                                                 input logic [7:0]   rc,
                                                 input sbox_lut_t    lut);
        ascon_state_t t;
        logic [4:0]   col;
        logic [4:0]   sub;
        t    = s;
        t.x2 = t.x2 ^ {56'd0, rc};
        for (int b = 0; b < 64; b++) begin
            col = {t.x0[b], t.x1[b], t.x2[b], t.x3[b], t.x4[b]};
            sub = lut[col];
            t.x0[b] = sub[4];
            t.x1[b] = sub[3];
            t.x2[b] = sub[2];
            t.x3[b] = sub[1];
            t.x4[b] = sub[0];
        end
        t.x0 = t.x0 ^ ror64(t.x0, 19) ^ ror64(t.x0, 28);
        t.x1 = t.x1 ^ ror64(t.x1, 61) ^ ror64(t.x1, 39);
        t.x2 = t.x2 ^ ror64(t.x2, 1)  ^ ror64(t.x2, 6);
        t.x3 = t.x3 ^ ror64(t.x3, 10) ^ ror64(t.x3, 17);
        t.x4 = t.x4 ^ ror64(t.x4, 7)  ^ ror64(t.x4, 41);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_init_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_init_core_if
//  Purpose  : Request / result / S-box-update bundle of ascon_init_core.
//  Ports    : in_valid/in_ready + key_i/nonce_i   (init request)
//             out_valid/out_ready + x0_o..x4_o    (initialized state)
//             busy_o                              (RUN or DONE)
//             sbox_upd_valid/sbox_upd_ready + sbox_addr_i/sbox_data_i
//  Modports : master - requester / consumer side, slave - the core.
//  Revision : 1.0 - initial release
// ============================================================================
interface ascon_init_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_i;
    logic [127:0] nonce_i;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  x0_o;
    logic [63:0]  x1_o;
    logic [63:0]  x2_o;
    logic [63:0]  x3_o;
    logic [63:0]  x4_o;
    logic         busy_o;
    logic         sbox_upd_valid;
    logic         sbox_upd_ready;
    logic [4:0]   sbox_addr_i;
    logic [19:0]  sbox_data_i;

    modport master (
        output in_valid, key_i, nonce_i, out_ready,
               sbox_upd_valid, sbox_addr_i, sbox_data_i,
        input  in_ready, out_valid, x0_o, x1_o, x2_o, x3_o, x4_o,
               busy_o, sbox_upd_ready
    );

    modport slave (
        input  in_valid, key_i, nonce_i, out_ready,
               sbox_upd_valid, sbox_addr_i, sbox_data_i,
        output in_ready, out_valid, x0_o, x1_o, x2_o, x3_o, x4_o,
               busy_o, sbox_upd_ready
    );
endinterface
`default_nettype wire

// File: rtl/ascon_init_core_asconp_lut.sv
`default_nettype none
// ============================================================================
//  Module   : asconp_lut
//  Purpose  : UROL unrolled Ascon rounds using a runtime-writable S-box LUT.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             state_i / state_o - state before / after UROL rounds
//             round_cnt_i       - rounds still to go; selects round constants
//             upd_sbox_i        - write strobe for the LUT
//             sbox_addr_i       - base entry of the write
//             sbox_data_i       - four 5-bit entries; [5j+4:5j] -> addr+j
//  Revision : 1.0 - initial release
// ============================================================================
module asconp_lut
    import ascon_pkg::*;
#(
    parameter int unsigned UROL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ascon_state_t state_i,
    input  logic [3:0]   round_cnt_i,
    input  logic         upd_sbox_i,
    input  logic [4:0]   sbox_addr_i,
    input  logic [19:0]  sbox_data_i,
    output ascon_state_t state_o
);
    sbox_lut_t    lut_q;
    ascon_state_t stage [UROL+1];

    // A write covers four consecutive entries, wrapping at 32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q <= ASCON_SBOX;
        end else if (upd_sbox_i) begin
            for (int j = 0; j < 4; j++) begin
                lut_q[sbox_addr_i + 5'(j)] <= sbox_data_i[5*j +: 5];
            end
        end
    end

    assign stage[0] = state_i;

    for (genvar i = 0; i < UROL; i++) begin : g_round
        logic [3:0] r_idx;
        // Round index 12 - round_cnt + i; constant byte is {15-r, r}.
        assign r_idx        = 4'(ROUNDS_A) - round_cnt_i + 4'(i);
        assign stage[i + 1] = ascon_round(stage[i], {~r_idx, r_idx}, lut_q);
    end

    assign state_o = stage[UROL];
endmodule
`default_nettype wire

// File: rtl/ascon_init_core.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_init_core
//  Purpose  : Ascon-128 initialization: load IV||K||N, run p^12 at UROL
//             rounds per clock, XOR the key into x3/x4, hand the state
//             downstream. S-box LUT writes are only let through while idle.
//  Ports    : clk, rst_n - clock, async active-low reset
//             io         - ascon_init_core_if.slave (request, result, busy,
//                          S-box update)
//  Revision : 1.0 - initial release
// ============================================================================
module ascon_init_core
    import ascon_pkg::*;
#(
    parameter int unsigned UROL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ascon_init_core_if.slave io
);
    localparam logic [3:0] c_urol   = 4'(UROL);
    localparam logic [3:0] c_rounds = 4'(ROUNDS_A);

    if ((ROUNDS_A % UROL) != 0) begin : g_urol_check
        $error("ascon_init_core: UROL=%0d does not divide ROUNDS_A", UROL);
    end

    init_state_e  fsm_q;
    ascon_state_t state_q;
    ascon_state_t state_d;
    ascon_state_t perm_state;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic         upd_sbox;
    logic         accept;

    // The LUT may only change while no permutation is in flight.
    assign upd_sbox = (fsm_q == IDLE) && io.sbox_upd_valid;
    // An S-box update wins over a simultaneous init request.
    assign accept   = (fsm_q == IDLE) && io.in_valid && !io.sbox_upd_valid;

    asconp_lut #(.UROL(UROL)) u_perm (
        .clk         (clk),
        .rst_n       (rst_n),
        .state_i     (state_q),
        .round_cnt_i (cnt_q),
        .upd_sbox_i  (upd_sbox),
        .sbox_addr_i (io.sbox_addr_i),
        .sbox_data_i (io.sbox_data_i),
        .state_o     (perm_state)
    );

    // Final key XOR is folded into the last permutation step.
    always_comb begin
        state_d = perm_state;
        if (cnt_q == c_urol) begin
            state_d.x3 = state_d.x3 ^ key_q[127:64];
            state_d.x4 = state_d.x4 ^ key_q[63:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= '{x0: ASCON128_IV,
                                     x1: io.key_i[127:64],  x2: io.key_i[63:0],
                                     x3: io.nonce_i[127:64], x4: io.nonce_i[63:0]};
                        key_q   <= io.key_i;
                        cnt_q   <= c_rounds;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    cnt_q   <= cnt_q - c_urol;
                    if (cnt_q == c_urol) begin
                        fsm_q <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready       = (fsm_q == IDLE) && !io.sbox_upd_valid;
    assign io.sbox_upd_ready = (fsm_q == IDLE);
    assign io.out_valid      = (fsm_q == DONE);
    assign io.busy_o         = (fsm_q != IDLE);
    assign io.x0_o           = state_q.x0;
    assign io.x1_o           = state_q.x1;
    assign io.x2_o           = state_q.x2;
    assign io.x3_o           = state_q.x3;
    assign io.x4_o           = state_q.x4;
endmodule
`default_nettype wire

// File: tb/tb_ascon_init_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_init_core
//  Purpose  : Self-checking bench. Five cores (UROL 1,2,3,4,6) share one
//             stimulus stream; results are compared with a software Ascon
//             model that holds its own copy of the S-box table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_init_core;
    localparam int NDUT = 5;
    localparam logic [127:0] c_kat = 128'h000102030405060708090A0B0C0D0E0F;

    function automatic int urol_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 6;
        endcase
    endfunction

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         out_ready;
    logic         sbox_upd_valid;
    logic [4:0]   sbox_addr;
    logic [19:0]  sbox_data;

    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic         busy_a      [NDUT];
    logic         upd_ready_a [NDUT];
    logic [63:0]  lanes_a     [NDUT][5];

    int errors = 0;
    int checks = 0;

    int ref_sbox [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                          30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
    int          sbox_m [32];
    logic [63:0] exp_l  [5];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ascon_init_core_if bus ();
        assign bus.in_valid       = in_valid;
        assign bus.key_i          = key;
        assign bus.nonce_i        = nonce;
        assign bus.out_ready      = out_ready;
        assign bus.sbox_upd_valid = sbox_upd_valid;
        assign bus.sbox_addr_i    = sbox_addr;
        assign bus.sbox_data_i    = sbox_data;
        assign in_ready_a[g]      = bus.in_ready;
        assign out_valid_a[g]     = bus.out_valid;
        assign busy_a[g]          = bus.busy_o;
        assign upd_ready_a[g]     = bus.sbox_upd_ready;
        assign lanes_a[g][0]      = bus.x0_o;
        assign lanes_a[g][1]      = bus.x1_o;
        assign lanes_a[g][2]      = bus.x2_o;
        assign lanes_a[g][3]      = bus.x3_o;
        assign lanes_a[g][4]      = bus.x4_o;
        ascon_init_core #(.UROL(urol_of(g))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Ascon p^12 over IV||K||N followed by the key XOR, column-wise S-box lookup.
    task automatic model_run(input logic [127:0] k, input logic [127:0] n);
        logic [63:0] s [5];
        logic [63:0] t [5];
        int          v;
        s[0] = 64'h80400C0600000000;
        s[1] = k[127:64];
        s[2] = k[63:0];
        s[3] = n[127:64];
        s[4] = n[63:0];
        for (int r = 0; r < 12; r++) begin
            s[2] = s[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                v = 0;
                for (int l = 0; l < 5; l++) v = v * 2 + int'(s[l][b]);
                v = sbox_m[v];
                for (int l = 0; l < 5; l++) t[l][b] = v[4 - l];
            end
            s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
            s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
            s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
            s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
            s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        end
        s[3] = s[3] ^ k[127:64];
        s[4] = s[4] ^ k[63:0];
        exp_l = s;
    endtask

    task automatic chk_idle_reset(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            chk({tag, "_in_ready"},  g, 64'(in_ready_a[g]),  64'd1);
            chk({tag, "_upd_ready"}, g, 64'(upd_ready_a[g]), 64'd1);
            chk({tag, "_out_valid"}, g, 64'(out_valid_a[g]), 64'd0);
            chk({tag, "_busy"},      g, 64'(busy_a[g]),      64'd0);
            for (int l = 0; l < 5; l++) chk({tag, "_lane"}, g, lanes_a[g][l], 64'd0);
        end
    endtask

    task automatic chk_done(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            chk({tag, "_out_valid"}, g, 64'(out_valid_a[g]), 64'd1);
            chk({tag, "_in_ready"},  g, 64'(in_ready_a[g]),  64'd0);
            for (int l = 0; l < 5; l++) chk({tag, "_lane"}, g, lanes_a[g][l], exp_l[l]);
        end
    endtask

    // Full init: accept, measure latency under noisy ignored inputs, hold the
    // result for 'hold' stalled cycles, then complete the output handshake.
    task automatic do_init(input logic [127:0] k, input logic [127:0] n, input int hold);
        int lat [NDUT];
        model_run(k, n);
        key = k; nonce = n; in_valid = 1'b1; sbox_upd_valid = 1'b0; out_ready = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) chk("accept_in_ready", g, 64'(in_ready_a[g]), 64'd1);
        tick();
        for (int g = 0; g < NDUT; g++) lat[g] = -1;
        for (int c = 1; c <= 12; c++) begin
            in_valid = 1'($urandom); key = rand128(); nonce = rand128();
            sbox_upd_valid = 1'($urandom); sbox_addr = 5'($urandom); sbox_data = 20'($urandom);
            #1;
            for (int g = 0; g < NDUT; g++) chk("busy_upd_ready", g, 64'(upd_ready_a[g]), 64'd0);
            tick();
            for (int g = 0; g < NDUT; g++)
                if (lat[g] < 0 && out_valid_a[g]) lat[g] = c;
        end
        in_valid = 1'b0; sbox_upd_valid = 1'b0;
        for (int g = 0; g < NDUT; g++) chk("latency", g, 64'(lat[g]), 64'(12 / urol_of(g)));
        chk_done("done");
        for (int h = 0; h < hold; h++) begin
            tick();
            chk_done("stall");
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            chk("post_hs_in_ready",  g, 64'(in_ready_a[g]),  64'd1);
            chk("post_hs_out_valid", g, 64'(out_valid_a[g]), 64'd0);
            chk("post_hs_busy",      g, 64'(busy_a[g]),      64'd0);
        end
    endtask

    initial begin
        logic [127:0] k;
        logic [19:0]  d;
        logic [4:0]   a;
        sbox_m = ref_sbox;
        rst_n = 1'b0; in_valid = 1'b0; key = '0; nonce = '0; out_ready = 1'b0;
        sbox_upd_valid = 1'b0; sbox_addr = '0; sbox_data = '0;
        repeat (3) tick();
        chk_idle_reset("reset");
        rst_n = 1'b1;
        tick();

        // Known-answer vector, then random vectors with short stalls.
        do_init(c_kat, c_kat, 0);
        for (int i = 0; i < 4; i++) do_init(rand128(), rand128(), $urandom_range(0, 3));
        // Long backpressure.
        do_init(rand128(), rand128(), 20);

        // Update and init requested together: update wins, init waits a cycle.
        a = 5'($urandom); d = 20'($urandom);
        in_valid = 1'b1; key = rand128(); nonce = rand128();
        sbox_upd_valid = 1'b1; sbox_addr = a; sbox_data = d;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk("arb_in_ready",  g, 64'(in_ready_a[g]),  64'd0);
            chk("arb_upd_ready", g, 64'(upd_ready_a[g]), 64'd1);
        end
        tick();
        for (int g = 0; g < NDUT; g++) chk("arb_deferred_busy", g, 64'(busy_a[g]), 64'd0);
        for (int j = 0; j < 4; j++) sbox_m[(int'(a) + j) % 32] = int'(d[5*j +: 5]);
        do_init(rand128(), rand128(), 1);

        // Asynchronous reset in the middle of a run.
        k = rand128();
        key = k; nonce = rand128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk_idle_reset("async_reset");
        sbox_m = ref_sbox;
        tick();
        rst_n = 1'b1;
        tick();
        do_init(c_kat, c_kat, 0);

        // Identity S-box loaded through eight four-entry writes.
        for (int i = 0; i < 8; i++) begin
            sbox_upd_valid = 1'b1;
            sbox_addr = 5'(4 * i);
            sbox_data = {5'(4 * i + 3), 5'(4 * i + 2), 5'(4 * i + 1), 5'(4 * i)};
            #1;
            for (int g = 0; g < NDUT; g++) chk("ident_upd_ready", g, 64'(upd_ready_a[g]), 64'd1);
            tick();
        end
        sbox_upd_valid = 1'b0;
        for (int i = 0; i < 32; i++) sbox_m[i] = i;
        do_init(rand128(), rand128(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
